// File: rtl/if_stage_prefetch.sv
// Decoupled instruction fetch stage: issues up to IBUF_DEPTH outstanding reads
// on a split-handshake SRAM-like bus, collects the returned words in an in-order
// buffer, and hands {adef, pc, inst} to ID. Redirects empty the buffer and mark
// every still-outstanding response for silent discard.
module if_stage_prefetch #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int          IBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_allowin,
   output logic        fs_to_ds_valid,
   output logic [64:0] fs_to_ds_bus,
   input  logic [32:0] br_bus,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   localparam int PW = $clog2(IBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(IBUF_DEPTH);

   // control state
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          halt_q, halt_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] fill_q, fill_d;       // oldest entry still waiting for data
   logic [CW-1:0] count_q, count_d;     // allocated entries
   logic [CW-1:0] pending_q, pending_d; // allocated entries with a read outstanding
   logic [CW-1:0] cancel_q, cancel_d;   // outstanding reads whose data is to be dropped

   // buffer entries
   logic          filled_q [IBUF_DEPTH];
   logic          adef_q   [IBUF_DEPTH];
   logic [31:0]   pc_q     [IBUF_DEPTH];
   logic [31:0]   inst_q   [IBUF_DEPTH];

   logic          br_taken;
   logic [31:0]   br_target;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [CW:0]   credit_sum;
   logic          credit_ok;
   logic          aligned;
   logic          fetch_ok;
   logic          alloc_req;
   logic          alloc_adef;
   logic          alloc;
   logic          fill;
   logic          pop;
   logic [IBUF_DEPTH-1:0] alloc_we;
   logic [IBUF_DEPTH-1:0] fill_we;

   assign br_taken    = br_bus[32];
   assign br_target   = br_bus[31:0];
   assign redirect    = flush | br_taken;
   assign redirect_pc = flush ? flush_target : br_target;

   // A slot is free only if neither live entries nor doomed responses claim it,
   // so every data_ok always has an entry or a cancel credit waiting for it.
   assign credit_sum  = {1'b0, count_q} + {1'b0, cancel_q};
   assign credit_ok   = credit_sum < DEPTH_W;
   assign aligned     = (fetch_pc_q[1:0] == 2'b00);
   assign fetch_ok    = resetn & ~halt_q & ~redirect & credit_ok;

   assign inst_sram_req   = fetch_ok & aligned;
   assign inst_sram_addr  = fetch_pc_q;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0;

   assign alloc_req  = inst_sram_req & inst_sram_addr_ok;
   assign alloc_adef = fetch_ok & ~aligned;
   assign alloc      = alloc_req | alloc_adef;
   assign fill       = inst_sram_data_ok & (cancel_q == '0);

   assign fs_to_ds_valid = resetn & (count_q != '0) & filled_q[head_q] & ~redirect;
   assign fs_to_ds_bus   = {adef_q[head_q], pc_q[head_q], inst_q[head_q]};
   assign pop            = fs_to_ds_valid & id_allowin;

   // per-entry write enables for allocation and fill
   generate
      for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_we
         assign alloc_we[gi] = alloc & (tail_q == PW'(gi));
         assign fill_we[gi]  = fill & (fill_q == PW'(gi));
      end
   endgenerate

   // next-state for pointers, counters, fetch pc and halt
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halt_d     = halt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fill_d     = fill_q;
      count_d    = count_q;
      pending_d  = pending_q;
      cancel_d   = cancel_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         halt_d     = 1'b0;
         head_d     = tail_q;
         fill_d     = tail_q;
         count_d    = '0;
         pending_d  = '0;
         // A data_ok this cycle retires either a cancel credit or one pending
         // read; both cases remove exactly one from what must be dropped.
         cancel_d   = cancel_q + pending_q - CW'(inst_sram_data_ok);
      end else begin
         if (alloc_req)  fetch_pc_d = fetch_pc_q + 32'd4;
         if (alloc_adef) halt_d     = 1'b1;
         if (alloc)      tail_d     = tail_q + PW'(1);
         if (pop)        head_d     = head_q + PW'(1);
         if (fill)       fill_d     = fill_q + PW'(1);
         count_d   = count_q + CW'(alloc) - CW'(pop);
         pending_d = pending_q + CW'(alloc_req) - CW'(fill);
         cancel_d  = cancel_q - CW'(inst_sram_data_ok & ~fill);
      end
   end

   // control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         halt_q     <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         pending_q  <= '0;
         cancel_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halt_q     <= halt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_q     <= fill_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         cancel_q   <= cancel_d;
      end
   end

   // buffer storage; validity is tracked by count, so no reset is needed here
   always_ff @(posedge clk) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
         if (alloc_we[i]) begin
            filled_q[i] <= alloc_adef;
            adef_q[i]   <= alloc_adef;
            pc_q[i]     <= fetch_pc_q;
            inst_q[i]   <= 32'h0;
         end
         if (fill_we[i]) begin
            filled_q[i] <= 1'b1;
            inst_q[i]   <= inst_sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: an in-order SRAM-like slave with programmable
// data latency, a scoreboard queue of expected deliveries filled by the
// directed tests, and a monitor that pops and compares on every ID handshake.
module tb_if_stage_prefetch;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        id_allowin = 1'b0;
   logic        fs_to_ds_valid;
   logic [64:0] fs_to_ds_bus;
   logic [32:0] br_bus = 33'h0;
   logic        flush = 1'b0;
   logic [31:0] flush_target = 32'h0;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok = 1'b0;
   logic        inst_sram_data_ok = 1'b0;
   logic [31:0] inst_sram_rdata = 32'h0;

   always #5 clk = ~clk;

   if_stage_prefetch #(
      .RESET_PC   (32'h1c000000),
      .IBUF_DEPTH (4)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .id_allowin        (id_allowin),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .br_bus            (br_bus),
      .flush             (flush),
      .flush_target      (flush_target),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   int ntests = 0;
   int nfail  = 0;
   logic [64:0] sb[$];     // expected {adef, pc, inst} in delivery order
   logic [31:0] acc[$];    // addresses the slave accepted
   bit  mon_en = 1'b0;
   bit  strict = 1'b0;     // delivery with an empty scoreboard counts as an error
   int  lat = 1;
   int  edge_cnt = 0;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pq[$];

   // memory contents: a fixed scramble of the address
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      sb.push_back({1'b0, pc, inst_of(pc)});
   endtask

   // bus slave: accepts on req & addr_ok, returns data in order `lat` edges later
   always @(posedge clk) begin
      edge_cnt++;
      if (!resetn) begin
         pq.delete();
      end else if (inst_sram_req && inst_sram_addr_ok) begin
         pq.push_back('{addr: inst_sram_addr, due: edge_cnt + lat});
         acc.push_back(inst_sram_addr);
      end
      #1;
      if (pq.size() > 0 && pq[0].due <= edge_cnt + 1) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = inst_of(pq[0].addr);
         void'(pq.pop_front());
      end else begin
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = 32'h0;
      end
   end

   // monitor: compare every instruction handed to ID against the scoreboard
   always @(negedge clk) begin
      if (mon_en && resetn && fs_to_ds_valid && id_allowin) begin
         $display("[TB] deliver adef=%0d pc=%h inst=%h", fs_to_ds_bus[64],
                  fs_to_ds_bus[63:32], fs_to_ds_bus[31:0]);
         if (sb.size() > 0) begin
            chk("deliver", fs_to_ds_bus, sb.pop_front());
         end else if (strict) begin
            chk("unexpected_deliver", fs_to_ds_bus, 65'h0);
            if (fs_to_ds_bus == 65'h0) begin
               ntests++;
               nfail++;
               $display("[TB] FAIL unexpected_deliver: got a delivery, required none");
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      ntests++;
      if (sb.size() != 0) begin
         nfail++;
         $display("[TB] FAIL %s: %0d deliveries missing after %0d cycles, required 0",
                  name, sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetn     = 1'b0;
      mon_en     = 1'b0;
      strict     = 1'b0;
      id_allowin = 1'b0;
      br_bus     = 33'h0;
      flush      = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 65'(fs_to_ds_valid), 65'h0);
      chk("reset_req", 65'(inst_sram_req), 65'h0);
      @(posedge clk);
      #1;
      sb.delete();
      acc.delete();
      resetn = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int b;
      int n0;

      // reset state and constant bus fields
      do_reset();
      chk("const_wr", 65'(inst_sram_wr), 65'h0);
      chk("const_size", 65'(inst_sram_size), 65'h2);
      chk("const_wstrb", 65'(inst_sram_wstrb), 65'h0);
      chk("const_wdata", 65'(inst_sram_wdata), 65'h0);

      // streaming: 1-cycle slave, ID always ready
      lat = 1;
      inst_sram_addr_ok = 1'b1;
      id_allowin = 1'b1;
      for (int i = 0; i < 8; i++) push_exp(32'h1c000000 + 32'(4 * i));
      k = 0;
      @(negedge clk);
      while (!fs_to_ds_valid && k < 20) begin
         k++;
         @(negedge clk);
      end
      chk("startup_cycles", 65'(k), 65'd2);
      b = 0;
      repeat (7) begin
         @(negedge clk);
         if (fs_to_ds_valid) b++;
      end
      chk("stream_back_to_back", 65'(b), 65'd7);
      wait_drain("stream_drain", 40);
      for (int i = 0; i < 8; i++) begin
         if (i < acc.size()) chk("stream_addr", 65'(acc[i]), 65'(32'h1c000000 + 32'(4 * i)));
         else chk("stream_addr_count", 65'(acc.size()), 65'(i + 1));
      end

      // backpressure: ID stalled, at most IBUF_DEPTH reads accepted
      do_reset();
      lat = 1;
      id_allowin = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("bp_accepted", 65'(acc.size()), 65'd4);
      chk("bp_req_low", 65'(inst_sram_req), 65'h0);
      chk("bp_valid", 65'(fs_to_ds_valid), 65'h1);
      for (int i = 0; i < 8; i++) push_exp(32'h1c000000 + 32'(4 * i));
      @(posedge clk);
      #1;
      id_allowin = 1'b1;
      b = 0;
      repeat (4) begin
         @(negedge clk);
         if (fs_to_ds_valid) b++;
      end
      chk("bp_drain_back_to_back", 65'(b), 65'd4);
      wait_drain("bp_drain", 40);

      // branch with three reads outstanding on a slow slave
      do_reset();
      lat = 4;
      id_allowin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("br_inflight", 65'(acc.size()), 65'd3);
      br_bus = {1'b1, 32'h1c000100};
      for (int i = 0; i < 4; i++) push_exp(32'h1c000100 + 32'(4 * i));
      @(posedge clk);
      #1;
      br_bus = 33'h0;
      wait_drain("br_drain", 80);
      if (acc.size() > 3) chk("br_next_addr", 65'(acc[3]), 65'(32'h1c000100));
      else chk("br_next_addr_count", 65'(acc.size()), 65'd4);

      // flush and branch together: flush target wins, nothing handed to ID
      do_reset();
      lat = 1;
      id_allowin = 1'b1;
      mon_en = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n0 = acc.size();
      flush = 1'b1;
      flush_target = 32'h1c008000;
      br_bus = {1'b1, 32'h1c000200};
      sb.delete();
      for (int i = 0; i < 4; i++) push_exp(32'h1c008000 + 32'(4 * i));
      mon_en = 1'b1;
      @(negedge clk);
      chk("flush_valid_low", 65'(fs_to_ds_valid), 65'h0);
      chk("flush_req_low", 65'(inst_sram_req), 65'h0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      br_bus = 33'h0;
      wait_drain("flush_drain", 40);
      if (acc.size() > n0) chk("flush_next_addr", 65'(acc[n0]), 65'(32'h1c008000));
      else chk("flush_next_addr_count", 65'(acc.size()), 65'(n0 + 1));

      // misaligned branch target: ADEF entry, fetch halted until a flush
      do_reset();
      lat = 1;
      id_allowin = 1'b1;
      mon_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      br_bus = {1'b1, 32'h1c000102};
      sb.delete();
      sb.push_back({1'b1, 32'h1c000102, 32'h0});
      mon_en = 1'b1;
      strict = 1'b1;
      @(posedge clk);
      #1;
      br_bus = 33'h0;
      n0 = acc.size();
      repeat (8) begin
         @(negedge clk);
         chk("adef_req_low", 65'(inst_sram_req), 65'h0);
      end
      chk("adef_delivered", 65'(sb.size()), 65'h0);
      chk("adef_no_accept", 65'(acc.size()), 65'(n0));
      @(posedge clk);
      #1;
      strict = 1'b0;
      flush = 1'b1;
      flush_target = 32'h1c008000;
      for (int i = 0; i < 3; i++) push_exp(32'h1c008000 + 32'(4 * i));
      @(posedge clk);
      #1;
      flush = 1'b0;
      wait_drain("adef_resume", 40);
      if (acc.size() > n0) chk("adef_resume_addr", 65'(acc[n0]), 65'(32'h1c008000));
      else chk("adef_resume_count", 65'(acc.size()), 65'(n0 + 1));

      // reset with two reads outstanding
      do_reset();
      lat = 3;
      id_allowin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inflight", 65'(acc.size()), 65'd2);
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 65'(fs_to_ds_valid), 65'h0);
      chk("rst_req", 65'(inst_sram_req), 65'h0);
      @(posedge clk);
      #1;
      acc.delete();
      sb.delete();
      resetn = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("rst_full_credit", 65'(acc.size()), 65'd4);
      for (int i = 0; i < 6; i++) push_exp(32'h1c000000 + 32'(4 * i));
      @(posedge clk);
      #1;
      id_allowin = 1'b1;
      wait_drain("rst_drain", 60);
      if (acc.size() > 0) chk("rst_first_addr", 65'(acc[0]), 65'(32'h1c000000));
      else chk("rst_first_addr_count", 65'(acc.size()), 65'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
